fib_request_scheduler: RTL and testbench

Shares one double-rate Fibonacci datapath between `N_REQ` requesters. Each requester submits an index `n`, and the block returns F(n) tagged with the requester id.
- Requests are arbitrated round-robin.
- The adder pair is sequenced two terms per cycle.
- Each result is held until the consumer accepts it.
- The block sits between client logic and the Fibonacci arithmetic, and owns that arithmetic internally.

---
 rtl/fib_request_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_fib_request_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_request_scheduler.sv
// ---------------------------------------------------------------------------
// fib_request_scheduler
//
// Shares one double-rate Fibonacci datapath between N_REQ requesters. A
// round-robin arbiter accepts one index n at a time; the datapath advances
// two terms per cycle and the result F(n) mod 2^W is held, tagged with the
// requester id, until the consumer accepts it.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   req_valid    in   [N_REQ]        request pending per requester
//   req_index    in   [N_REQ*IDX_W]  index n of requester i at [i*IDX_W +: IDX_W]
//   req_ready    out  [N_REQ]        one-hot grant, only while idle
//   rsp_valid    out                 result available
//   rsp_ready    in                  consumer accepts result
//   rsp_data     out  [W]            F(n) mod 2^W
//   rsp_id       out  [ID_W]         requester that issued the request
//   rsp_overflow out                 true F(n) >= 2^W
//   busy         out                 a request is in flight or being returned
// ---------------------------------------------------------------------------
module fib_request_scheduler #(
    parameter int N_REQ = 2,
    parameter int W     = 16,
    parameter int IDX_W = 6,
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*IDX_W-1:0] req_index,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [W-1:0]           rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_overflow,
    output logic                   busy
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   cur_id_q, cur_id_d;
    logic              n_odd_q, n_odd_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [W-1:0]      a_q, a_d, b_q, b_d;
    logic              ova_q, ova_d, ovb_q, ovb_d;
    logic [W-1:0]      rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic              rsp_ovf_q, rsp_ovf_d;

    // Per-requester view of the packed index bus.
    logic [IDX_W-1:0]  idx_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_idx
            assign idx_arr[gi] = req_index[gi*IDX_W +: IDX_W];
        end
    endgenerate

    // Round-robin grant: first valid requester at or after rr_ptr, with wrap.
    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   grant_id;
    logic              grant_any;

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        if (state_q == S_IDLE && rst_n) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= N_REQ) begin
                    idx = idx - N_REQ;
                end
                if (!grant_any && req_valid[idx]) begin
                    grant_any  = 1'b1;
                    grant_id   = ID_W'(idx);
                    grant[idx] = 1'b1;
                end
            end
        end
    end

    // Double-rate step: (a,b) <- (a+b, a+2b). Two extra bits hold the carry
    // out of a+2b, which can reach 3*(2^W - 1).
    logic [W+1:0] sum_ab, sum_a2b;
    logic [IDX_W-1:0] sel_idx;

    assign sum_ab  = {2'b00, a_q} + {2'b00, b_q};
    assign sum_a2b = {2'b00, a_q} + {1'b0, b_q, 1'b0};
    assign sel_idx = idx_arr[grant_id];

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        cur_id_d   = cur_id_q;
        n_odd_d    = n_odd_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        ova_d      = ova_q;
        ovb_d      = ovb_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        rsp_ovf_d  = rsp_ovf_q;
        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    rr_ptr_d = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
                    cur_id_d = grant_id;
                    n_odd_d  = sel_idx[0];
                    ova_d    = 1'b0;
                    ovb_d    = 1'b0;
                    state_d  = S_RUN;
                    if (sel_idx == '0) begin
                        // n=0 takes the same single RUN cycle as n=1/2 so all
                        // three share latency 1; b=0 is selected for even n.
                        cnt_d = '0;
                        a_d   = '0;
                        b_d   = '0;
                    end else begin
                        cnt_d = (sel_idx - IDX_W'(1)) >> 1;
                        a_d   = W'(1);
                        b_d   = W'(1);
                    end
                end
            end
            S_RUN: begin
                if (cnt_q == '0) begin
                    rsp_data_d = n_odd_q ? a_q : b_q;
                    rsp_ovf_d  = n_odd_q ? ova_q : ovb_q;
                    rsp_id_d   = cur_id_q;
                    state_d    = S_DONE;
                end else begin
                    // Overflow is sticky and spreads to both terms, since
                    // every later term is at least as large as either.
                    a_d   = sum_ab[W-1:0];
                    b_d   = sum_a2b[W-1:0];
                    ova_d = ova_q | ovb_q | (|sum_ab[W+1:W]);
                    ovb_d = ova_q | ovb_q | (|sum_a2b[W+1:W]);
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            cur_id_q   <= '0;
            n_odd_q    <= 1'b0;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            ova_q      <= 1'b0;
            ovb_q      <= 1'b0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
            rsp_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            cur_id_q   <= cur_id_d;
            n_odd_q    <= n_odd_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            ova_q      <= ova_d;
            ovb_q      <= ovb_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            rsp_ovf_q  <= rsp_ovf_d;
        end
    end

    assign req_ready    = grant;
    assign rsp_valid    = (state_q == S_DONE);
    assign rsp_data     = rsp_data_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_overflow = rsp_ovf_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_fib_request_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fib_request_scheduler
//
// Directed bench for fib_request_scheduler (N_REQ=2, W=16, IDX_W=6). A
// transaction-level model (true Fibonacci in 64-bit arithmetic, round-robin
// pointer, expected latency) is compared against the DUT on every falling
// edge; the directed sequence adds hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_fib_request_scheduler;

    localparam int NR  = 2;
    localparam int W   = 16;
    localparam int IW  = 6;
    localparam int IDW = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*IW-1:0]  req_index = '0;
    logic [NR-1:0]     req_ready;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [W-1:0]      rsp_data;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_overflow;
    logic              busy;

    int vecs = 0;
    int miss = 0;

    fib_request_scheduler #(.N_REQ(NR), .W(W), .IDX_W(IW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_index    (req_index),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_id       (rsp_id),
        .rsp_overflow (rsp_overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        vecs++;
        miss++;
        $display("FAIL %s: timed out (t=%0t)", nm, $time);
    endtask

    // True F(n) in 64 bits (F(63) fits), then reduced to W bits.
    function automatic void fib_ref(input int n, output logic [W-1:0] d, output logic ov);
        longint unsigned x, y, t;
        x = 0;
        y = 1;
        for (int i = 0; i < n; i++) begin
            t = x + y;
            x = y;
            y = t;
        end
        d  = x[W-1:0];
        ov = (x >= (64'd1 << W));
    endfunction

    function automatic logic [NR-1:0] model_grant(input logic [NR-1:0] v, input int ptr);
        logic [NR-1:0] g;
        logic found;
        int i;
        g = '0;
        found = 1'b0;
        for (int k = 0; k < NR; k++) begin
            i = (ptr + k) % NR;
            if (!found && v[i]) begin
                g[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return g;
    endfunction

    // ---------------- model + per-cycle compare ----------------
    // m_phase: 0 = waiting for a request, 1 = computing, 2 = result held.
    int            m_phase = 0;
    int            m_left  = 0;
    int            m_rr    = 0;
    int            m_id    = 0;
    int            m_n     = 0;
    logic [W-1:0]  m_data  = '0;
    logic          m_ov    = 1'b0;
    logic [NR-1:0] m_eg;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_phase = 0;
            m_rr    = 0;
        end
        m_eg = (m_phase == 0 && rst_n) ? model_grant(req_valid, m_rr) : '0;
        chk("req_ready", 64'(req_ready), 64'(m_eg));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_phase == 2));
        chk("busy", 64'(busy), 64'(m_phase != 0));
        if (m_phase == 2) begin
            chk("rsp_data", 64'(rsp_data), 64'(m_data));
            chk("rsp_id", 64'(rsp_id), 64'(m_id));
            chk("rsp_overflow", 64'(rsp_overflow), 64'(m_ov));
        end
        if (rst_n) begin
            case (m_phase)
                0: if (m_eg != '0) begin
                    m_id   = m_eg[1] ? 1 : 0;
                    m_n    = int'(req_index[m_id*IW +: IW]);
                    fib_ref(m_n, m_data, m_ov);
                    m_left = (m_n == 0) ? 1 : ((m_n - 1) >> 1) + 1;
                    m_rr   = (m_id + 1) % NR;
                    m_phase = 1;
                end
                1: begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_phase = 2;
                end
                default: if (rsp_ready) m_phase = 0;
            endcase
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic send(input int id, input int n);
        bit ok;
        req_index[id*IW +: IW] = IW'(n);
        req_valid[id] = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            if (req_ready[id]) ok = 1'b1;
        end
        if (!ok) timeout("send_grant");
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!rsp_valid) timeout("wait_rsp");
    endtask

    task automatic run_one(input int id, input int n, input int ed, input int eov, input int elat);
        int lat;
        send(id, n);
        wait_rsp(lat);
        chk($sformatf("latency_n%0d", n), 64'(lat), 64'(elat));
        chk($sformatf("data_n%0d", n), 64'(rsp_data), 64'(ed));
        chk($sformatf("id_n%0d", n), 64'(rsp_id), 64'(id));
        chk($sformatf("ovf_n%0d", n), 64'(rsp_overflow), 64'(eov));
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] d63;
        logic         o63;
        int           got, lat, seen;
        logic [63:0]  ids [4];
        logic [63:0]  dats [4];
        logic [W-1:0] held;

        // Reset state, with a request pending that must not be granted.
        req_valid = 2'b10;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_ovf", 64'(rsp_overflow), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        req_valid = '0;
        rst_n = 1'b1;

        run_one(0, 10, 55, 0, 5);
        run_one(0, 0, 0, 0, 1);
        run_one(0, 1, 1, 0, 1);
        run_one(0, 2, 1, 0, 1);
        run_one(0, 24, 46368, 0, 12);
        run_one(0, 25, 9489, 1, 13);
        fib_ref(63, d63, o63);
        run_one(1, 63, int'(d63), 1, 32);

        // Both requesters pending from reset: alternating grants.
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_index = {6'd4, 6'd3};
        req_valid = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got = 0;
        for (int c = 0; c < 400 && got < 4; c++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                ids[got]  = 64'(rsp_id);
                dats[got] = 64'(rsp_data);
                got++;
            end
        end
        if (got < 4) timeout("rr_responses");
        @(posedge clk);
        #1;
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < got) begin
                chk($sformatf("rr_id%0d", i), ids[i], 64'(i % 2));
                chk($sformatf("rr_data%0d", i), dats[i], (i % 2 == 0) ? 64'd2 : 64'd3);
            end
        end

        // Back-pressure: hold the response 10 cycles with requester 1 waiting.
        rsp_ready = 1'b0;
        req_index[IW +: IW] = 6'd6;
        req_valid[1] = 1'b1;
        send(0, 5);
        wait_rsp(lat);
        chk("stall_latency", 64'(lat), 64'd3);
        held = rsp_data;
        chk("stall_data", 64'(held), 64'd5);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("stall_hold_data", 64'(rsp_data), 64'd5);
            chk("stall_hold_valid", 64'(rsp_valid), 64'd1);
            chk("stall_hold_id", 64'(rsp_id), 64'd0);
            chk("stall_req_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_stall_grant", 64'(req_ready), 64'b10);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        wait_rsp(lat);
        chk("req1_latency", 64'(lat), 64'd3);
        chk("req1_data", 64'(rsp_data), 64'd8);
        chk("req1_id", 64'(rsp_id), 64'd1);
        @(posedge clk);
        #1;

        // Reset during RUN of n=40 discards the request.
        send(0, 40);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_busy", 64'(busy), 64'd0);
        chk("midrun_rst_valid", 64'(rsp_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        chk("no_rsp_after_rst", 64'(seen), 64'd0);
        run_one(0, 5, 5, 0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

endmodule
